// File: rtl/tag_req_queue.sv
// tag_req_queue
// Tracks outstanding DRAM-cache tag reads. Each accepted host request is
// stored in a circular buffer and, in parallel, issued once on the AXI AR
// channel through a single holding register. R beats accepted by the tag
// comparator retire the head entry, which is presented registered on
// fifo_data_o so the comparator sees a stable value.
//
// Ports
//   clk          single clock, rising edge
//   rst_n        asynchronous active-low reset
//   req_valid_i  host request valid
//   req_ready_o  host request ready (combinational)
//   req_data_i   {write flag, id[15:0], byte address[63:0]}
//   arvalid_o    AXI AR valid
//   arready_i    AXI AR ready
//   araddr_o     AXI AR address, tag-aligned (low byte zero)
//   rvalid_i     AXI R valid (observed)
//   rready_i     AXI R ready from tag comparator (observed)
//   fifo_data_o  registered head entry, zero when empty
//   empty_o      no entries held
//   full_o       DEPTH entries held
//   count_o      number of entries held
//   underflow_o  sticky: R beat seen while empty
module tag_req_queue #(
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       req_valid_i,
    output logic                       req_ready_o,
    input  logic [80:0]                req_data_i,
    output logic                       arvalid_o,
    input  logic                       arready_i,
    output logic [63:0]                araddr_o,
    input  logic                       rvalid_i,
    input  logic                       rready_i,
    output logic [80:0]                fifo_data_o,
    output logic                       empty_o,
    output logic                       full_o,
    output logic [$clog2(DEPTH):0]     count_o,
    output logic                       underflow_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [80:0]   mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          arvalid_q, arvalid_d;
    logic [63:0]   araddr_q, araddr_d;
    logic [80:0]   head_q, head_d;
    logic          underflow_q, underflow_d;

    logic push;
    logic r_beat;
    logic pop;

    assign full_o      = (count_q == CW'(DEPTH));
    assign empty_o     = (count_q == '0);
    // A stalled AR holds the only address slot, so nothing new may enter.
    assign req_ready_o = !full_o && !(arvalid_q && !arready_i);
    assign push        = req_valid_i && req_ready_o;
    assign r_beat      = rvalid_i && rready_i;
    assign pop         = r_beat && !empty_o;

    assign arvalid_o   = arvalid_q;
    assign araddr_o    = araddr_q;
    assign fifo_data_o = head_q;
    assign count_o     = count_q;
    assign underflow_o = underflow_q;

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        arvalid_d   = arvalid_q;
        araddr_d    = araddr_q;
        underflow_d = underflow_q;
        head_d      = '0;

        if (push) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        if (r_beat && empty_o) begin
            underflow_d = 1'b1;
        end

        // A new accept reloads the holding register even on the edge the
        // previous address handshakes, keeping AR back-to-back.
        if (push) begin
            arvalid_d = 1'b1;
            araddr_d  = {req_data_i[63:8], 8'h00};
        end else if (arvalid_q && arready_i) begin
            arvalid_d = 1'b0;
        end

        // The next head is being written this same edge only when the
        // queue is (or becomes) otherwise empty, so bypass the write data.
        if (count_d == '0) begin
            head_d = '0;
        end else if (push && (wr_ptr_q == rd_ptr_d)) begin
            head_d = req_data_i;
        end else begin
            head_d = mem_q[rd_ptr_d];
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= req_data_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            arvalid_q   <= 1'b0;
            araddr_q    <= '0;
            head_q      <= '0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            arvalid_q   <= arvalid_d;
            araddr_q    <= araddr_d;
            head_q      <= head_d;
            underflow_q <= underflow_d;
        end
    end

endmodule

// File: tb/tb_tag_req_queue.sv
module tb_tag_req_queue;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid_i = 1'b0;
    logic        req_ready_o;
    logic [80:0] req_data_i = '0;
    logic        arvalid_o;
    logic        arready_i = 1'b0;
    logic [63:0] araddr_o;
    logic        rvalid_i = 1'b0;
    logic        rready_i = 1'b0;
    logic [80:0] fifo_data_o;
    logic        empty_o;
    logic        full_o;
    logic [3:0]  count_o;
    logic        underflow_o;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    tag_req_queue #(.DEPTH(8)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid_i (req_valid_i),
        .req_ready_o (req_ready_o),
        .req_data_i  (req_data_i),
        .arvalid_o   (arvalid_o),
        .arready_i   (arready_i),
        .araddr_o    (araddr_o),
        .rvalid_i    (rvalid_i),
        .rready_i    (rready_i),
        .fifo_data_o (fifo_data_o),
        .empty_o     (empty_o),
        .full_o      (full_o),
        .count_o     (count_o),
        .underflow_o (underflow_o)
    );

    typedef struct {
        logic        rv;
        logic [80:0] data;
        logic        ar;
        logic        rvl;
        logic        rr;
        logic        e_rdy;
        logic        e_arv;
        logic [63:0] e_addr;
        logic [3:0]  e_cnt;
        logic        e_emp;
        logic        e_full;
        logic [80:0] e_fdata;
        logic        e_uf;
    } vec_t;

    vec_t tbl[11];

    function automatic logic [80:0] mk(input logic wr, input logic [15:0] id,
                                       input logic [63:0] addr);
        return {wr, id, addr};
    endfunction

    task automatic chk(input string name, input logic [80:0] act, input logic [80:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic rv, input logic [80:0] d, input logic ar,
                         input logic rvl, input logic rr);
        @(negedge clk);
        req_valid_i = rv;
        req_data_i  = d;
        arready_i   = ar;
        rvalid_i    = rvl;
        rready_i    = rr;
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n       = 1'b0;
        req_valid_i = 1'b0;
        req_data_i  = '0;
        arready_i   = 1'b0;
        rvalid_i    = 1'b0;
        rready_i    = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    logic [80:0] d1, d2, d3;
    logic [15:0] head_id;

    initial begin
        d1 = mk(1'b0, 16'd1, 64'h0A00);
        d2 = mk(1'b1, 16'd2, 64'h1400);
        d3 = mk(1'b0, 16'd3, 64'h1E37);
        //          rv    data  ar    rvl   rr    rdy   arv   addr      cnt   emp   full  fdata uf
        tbl[0]  = '{1'b1, d1,   1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 64'h0A00, 4'd1, 1'b0, 1'b0, d1,   1'b0};
        tbl[1]  = '{1'b0, '0,   1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 64'h0A00, 4'd1, 1'b0, 1'b0, d1,   1'b0};
        tbl[2]  = '{1'b1, d2,   1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 64'h1400, 4'd2, 1'b0, 1'b0, d1,   1'b0};
        tbl[3]  = '{1'b1, d3,   1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 64'h1400, 4'd2, 1'b0, 1'b0, d1,   1'b0};
        tbl[4]  = '{1'b1, d3,   1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 64'h1E00, 4'd3, 1'b0, 1'b0, d1,   1'b0};
        tbl[5]  = '{1'b0, '0,   1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 64'h1E00, 4'd3, 1'b0, 1'b0, d1,   1'b0};
        tbl[6]  = '{1'b0, '0,   1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 64'h1E00, 4'd2, 1'b0, 1'b0, d2,   1'b0};
        tbl[7]  = '{1'b0, '0,   1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 64'h1E00, 4'd1, 1'b0, 1'b0, d3,   1'b0};
        tbl[8]  = '{1'b0, '0,   1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 64'h1E00, 4'd0, 1'b1, 1'b0, '0,   1'b0};
        tbl[9]  = '{1'b0, '0,   1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 64'h1E00, 4'd0, 1'b1, 1'b0, '0,   1'b1};
        tbl[10] = '{1'b0, '0,   1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 64'h1E00, 4'd0, 1'b1, 1'b0, '0,   1'b1};

        // Reset state
        #2;
        chk("rst_arvalid", 81'(arvalid_o), 81'(0));
        chk("rst_empty", 81'(empty_o), 81'(1));
        chk("rst_count", 81'(count_o), 81'(0));
        do_reset();

        // Table-driven sequence: single push, AR stall, back-to-back AR,
        // in-order retire, underflow.
        for (int i = 0; i < 11; i++) begin
            drive(tbl[i].rv, tbl[i].data, tbl[i].ar, tbl[i].rvl, tbl[i].rr);
            cycle();
            chk($sformatf("v%0d_ready", i), 81'(req_ready_o), 81'(tbl[i].e_rdy));
            chk($sformatf("v%0d_arvalid", i), 81'(arvalid_o), 81'(tbl[i].e_arv));
            chk($sformatf("v%0d_araddr", i), 81'(araddr_o), 81'(tbl[i].e_addr));
            chk($sformatf("v%0d_count", i), 81'(count_o), 81'(tbl[i].e_cnt));
            chk($sformatf("v%0d_empty", i), 81'(empty_o), 81'(tbl[i].e_emp));
            chk($sformatf("v%0d_full", i), 81'(full_o), 81'(tbl[i].e_full));
            chk($sformatf("v%0d_fdata", i), fifo_data_o, tbl[i].e_fdata);
            chk($sformatf("v%0d_uflow", i), 81'(underflow_o), 81'(tbl[i].e_uf));
            $display("vector %0d count=%0d arvalid=%0b araddr=%h", i, count_o, arvalid_o, araddr_o);
        end

        // Asynchronous reset with an AR pending and underflow set
        drive(1'b1, d1, 1'b0, 1'b0, 1'b0);
        cycle();
        drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
        #3 rst_n = 1'b0;
        #1;
        chk("arst_arvalid", 81'(arvalid_o), 81'(0));
        chk("arst_araddr", 81'(araddr_o), 81'(0));
        chk("arst_count", 81'(count_o), 81'(0));
        chk("arst_empty", 81'(empty_o), 81'(1));
        chk("arst_full", 81'(full_o), 81'(0));
        chk("arst_fdata", fifo_data_o, 81'(0));
        chk("arst_uflow", 81'(underflow_o), 81'(0));
        $display("async reset applied mid-traffic");
        @(negedge clk);
        rst_n = 1'b1;

        // Fill to DEPTH, refuse a ninth request, then one pop reopens
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, mk(1'b0, 16'(i + 1), 64'(i + 1) << 8), 1'b1, 1'b0, 1'b0);
            cycle();
        end
        drive(1'b1, mk(1'b0, 16'd9, 64'h0900), 1'b1, 1'b0, 1'b0);
        #1;
        chk("full_ready", 81'(req_ready_o), 81'(0));
        chk("full_flag", 81'(full_o), 81'(1));
        cycle();
        chk("full_count", 81'(count_o), 81'(8));
        $display("filled queue count=%0d full=%0b", count_o, full_o);
        drive(1'b0, '0, 1'b1, 1'b1, 1'b1);
        cycle();
        chk("pop_full_count", 81'(count_o), 81'(7));
        chk("pop_full_ready", 81'(req_ready_o), 81'(1));
        head_id = fifo_data_o[79:64];
        chk("pop_full_head", 81'(head_id), 81'(2));
        $display("pop from full count=%0d ready=%0b", count_o, req_ready_o);

        // Simultaneous push/pop at count 4 across pointer wrap
        do_reset();
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, mk(1'b0, 16'(i + 1), 64'(i + 1) << 8), 1'b1, 1'b0, 1'b0);
            cycle();
        end
        chk("pp_start_count", 81'(count_o), 81'(4));
        for (int k = 0; k < 12; k++) begin
            drive(1'b1, mk(1'b0, 16'(k + 5), 64'(k + 5) << 8), 1'b1, 1'b1, 1'b1);
            cycle();
            head_id = fifo_data_o[79:64];
            chk($sformatf("pp%0d_count", k), 81'(count_o), 81'(4));
            chk($sformatf("pp%0d_head", k), 81'(head_id), 81'(k + 2));
            chk($sformatf("pp%0d_araddr", k), 81'(araddr_o), 81'(64'(k + 5) << 8));
            $display("push+pop %0d head id=%0d count=%0d", k, head_id, count_o);
        end
        for (int j = 0; j < 4; j++) begin
            drive(1'b0, '0, 1'b1, 1'b1, 1'b1);
            cycle();
            head_id = fifo_data_o[79:64];
            chk($sformatf("drain%0d_count", j), 81'(count_o), 81'(3 - j));
            chk($sformatf("drain%0d_head", j), 81'(head_id), (j < 3) ? 81'(14 + j) : 81'(0));
            $display("drain %0d head id=%0d count=%0d", j, head_id, count_o);
        end
        chk("drain_empty", 81'(empty_o), 81'(1));
        chk("drain_fdata", fifo_data_o, 81'(0));
        chk("drain_uflow", 81'(underflow_o), 81'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
